// File: rtl/gate_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// gate_pkg: gate function encodings and evaluation helpers
// Rev 1.0
// ------------------------------------------------------------------
package gate_pkg;

  localparam int GATE_AND  = 0;
  localparam int GATE_OR   = 1;
  localparam int GATE_NAND = 2;
  localparam int GATE_NOR  = 3;
  localparam int GATE_XOR  = 4;
  localparam int GATE_XNOR = 5;

  localparam int MAX_INPUTS = 16;

  // Only the low n bits of vec take part in the function.
  function automatic logic gate_eval(input int func, input logic [MAX_INPUTS-1:0] vec,
                                     input int n);
    logic all_one;
    logic any_one;
    logic parity;
    logic res;
    all_one = 1'b1;
    any_one = 1'b0;
    parity  = 1'b0;
    for (int i = 0; i < MAX_INPUTS; i++) begin
      if (i < n) begin
        all_one = all_one & vec[i];
        any_one = any_one | vec[i];
        parity  = parity ^ vec[i];
      end
    end
    case (func)
      GATE_AND:  res = all_one;
      GATE_OR:   res = any_one;
      GATE_NAND: res = ~all_one;
      GATE_NOR:  res = ~any_one;
      GATE_XOR:  res = parity;
      default:   res = ~parity;
    endcase
    return res;
  endfunction

  function automatic logic gate_reset_val(input int func);
    return gate_eval(func, '0, 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/logic_gate_n_filt_if.sv
`default_nettype none
// ------------------------------------------------------------------
// logic_gate_n_filt_if: gate inputs, enable and filtered outputs
// Rev 1.0
// ------------------------------------------------------------------
interface logic_gate_n_filt_if #(
  parameter int N = 3
);
  logic         en;
  logic [N-1:0] d;
  logic         y_raw;
  logic         y;
  logic         y_rise;
  logic         y_fall;

  modport master (
    output en,
    output d,
    input  y_raw,
    input  y,
    input  y_rise,
    input  y_fall
  );

  modport slave (
    input  en,
    input  d,
    output y_raw,
    output y,
    output y_rise,
    output y_fall
  );
endinterface
`default_nettype wire

// File: rtl/sync_chain.sv
`default_nettype none
// ------------------------------------------------------------------
// sync_chain: 1-bit async-reset synchroniser; STAGES=0 is a wire
// Rev 1.0
// ------------------------------------------------------------------
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  if (STAGES == 0) begin : g_bypass
    assign q = d;
  end else begin : g_flops
    logic [STAGES-1:0] stage;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        stage <= '0;
      end else begin
        stage <= (stage << 1) | STAGES'(d);
      end
    end

    assign q = stage[STAGES-1];
  end

endmodule
`default_nettype wire

// File: rtl/logic_gate_n_filt.sv
`default_nettype none
// ------------------------------------------------------------------
// logic_gate_n_filt: N-input selectable gate, synchronised inputs,
// stability filter on the output and registered edge pulses
// Rev 1.0
// ------------------------------------------------------------------
module logic_gate_n_filt
  import gate_pkg::*;
#(
  parameter int N           = 3,
  parameter int FUNC        = 3,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  logic_gate_n_filt_if.slave     bus
);

  if (N < 1 || N > MAX_INPUTS || FUNC < GATE_AND || FUNC > GATE_XNOR ||
      SYNC_STAGES < 0 || SYNC_STAGES > 3 ||
      FILT_CYCLES < 1 || FILT_CYCLES > 255) begin : g_param_check
    $error("logic_gate_n_filt: illegal parameter set");
  end

  localparam logic RESET_Y = gate_reset_val(FUNC);
  localparam int   CNT_W   = $clog2(FILT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

  logic [N-1:0]     ds;
  logic             raw;
  logic [CNT_W-1:0] cnt;
  logic             y_q;
  logic             rise_q;
  logic             fall_q;

  for (genvar i = 0; i < N; i++) begin : g_sync
    sync_chain #(
      .STAGES (SYNC_STAGES)
    ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (bus.d[i]),
      .q       (ds[i])
    );
  end

  assign raw = gate_eval(FUNC, MAX_INPUTS'(ds), N);

  // y only moves once raw has disagreed with it for FILT_CYCLES enabled edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      y_q    <= RESET_Y;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (bus.en) begin
        if (raw == y_q) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          y_q    <= raw;
          cnt    <= '0;
          rise_q <= raw;
          fall_q <= ~raw;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign bus.y_raw  = raw;
  assign bus.y      = y_q;
  assign bus.y_rise = rise_q;
  assign bus.y_fall = fall_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_gate_n_filt.sv
`default_nettype none
`timescale 1ns/1ps
// ------------------------------------------------------------------
// tb_logic_gate_n_filt: two configurations against a behavioural model
// Rev 1.0
// ------------------------------------------------------------------
module tb_logic_gate_n_filt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [3:0] d_v   [2];
  logic       en_v  [2];
  logic       dut_raw [2];
  logic       dut_y   [2];
  logic       dut_rise[2];
  logic       dut_fall[2];
  logic       mod_raw [2];
  logic       mod_y   [2];
  logic       mod_rise[2];
  logic       mod_fall[2];

  int vectors     = 0;
  int miscompares = 0;

  // Gate result from the count of ones among the n inputs.
  function automatic logic ref_gate(input int func, input int ones, input int n);
    case (func)
      0:       return ones == n;
      1:       return ones != 0;
      2:       return ones != n;
      3:       return ones == 0;
      4:       return (ones % 2) == 1;
      default: return (ones % 2) == 0;
    endcase
  endfunction

  // cfg0: NOR, N=3, SYNC=2, FILT=4.  cfg1: XOR, N=4, SYNC=0, FILT=1.
  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int N_G    = (g == 0) ? 3 : 4;
    localparam int FUNC_G = (g == 0) ? 3 : 4;
    localparam int SYNC_G = (g == 0) ? 2 : 0;
    localparam int FILT_G = (g == 0) ? 4 : 1;

    logic_gate_n_filt_if #(.N(N_G)) bus ();

    assign bus.en = en_v[g];
    assign bus.d  = d_v[g][N_G-1:0];

    logic_gate_n_filt #(
      .N           (N_G),
      .FUNC        (FUNC_G),
      .SYNC_STAGES (SYNC_G),
      .FILT_CYCLES (FILT_G)
    ) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
    );

    assign dut_raw[g]  = bus.y_raw;
    assign dut_y[g]    = bus.y;
    assign dut_rise[g] = bus.y_rise;
    assign dut_fall[g] = bus.y_fall;

    // Model: input history, then "disagreement streak" filter.
    logic [N_G-1:0] pipe [3];
    logic [N_G-1:0] ds_m;
    logic           raw_m;
    logic           y_m;
    logic           rise_m;
    logic           fall_m;
    int             streak;

    if (SYNC_G == 0) begin : g_nosync
      assign ds_m = d_v[g][N_G-1:0];
    end else begin : g_sync
      assign ds_m = pipe[SYNC_G-1];
    end

    assign raw_m = ref_gate(FUNC_G, $countones(ds_m), N_G);

    always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < 3; i++) pipe[i] <= '0;
        y_m    <= ref_gate(FUNC_G, 0, N_G);
        streak <= 0;
        rise_m <= 1'b0;
        fall_m <= 1'b0;
      end else begin
        pipe[0] <= d_v[g][N_G-1:0];
        for (int i = 1; i < 3; i++) pipe[i] <= pipe[i-1];
        rise_m <= 1'b0;
        fall_m <= 1'b0;
        if (en_v[g]) begin
          if (raw_m == y_m) begin
            streak <= 0;
          end else if (streak + 1 >= FILT_G) begin
            y_m    <= raw_m;
            streak <= 0;
            rise_m <= (raw_m == 1'b1);
            fall_m <= (raw_m == 1'b0);
          end else begin
            streak <= streak + 1;
          end
        end
      end
    end

    assign mod_raw[g]  = raw_m;
    assign mod_y[g]    = y_m;
    assign mod_rise[g] = rise_m;
    assign mod_fall[g] = fall_m;
  end

  task automatic check(input string name, input int g, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cfg%0d: got %b, expected %b at %0t", name, g, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      check("y_raw", g, dut_raw[g], mod_raw[g]);
      check("y", g, dut_y[g], mod_y[g]);
      check("y_rise", g, dut_rise[g], mod_rise[g]);
      check("y_fall", g, dut_fall[g], mod_fall[g]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    reset_n = 1'b0;
    en_v[0] = 1'b1;
    en_v[1] = 1'b1;
    d_v[0]  = 4'b0000;
    d_v[1]  = 4'b0000;
    ticks(3);
    check("rst_y", 0, dut_y[0], 1'b1);
    check("rst_raw", 0, dut_raw[0], 1'b1);
    check("rst_rise", 0, dut_rise[0], 1'b0);
    check("rst_fall", 0, dut_fall[0], 1'b0);
    check("rst_y", 1, dut_y[1], 1'b0);
    reset_n = 1'b1;

    // XOR stepping, one-clock lag with alternating pulses
    d_v[1] = 4'b0001; tick();
    check("xor_y_0001", 1, dut_y[1], 1'b1);
    check("xor_rise_0001", 1, dut_rise[1], 1'b1);
    d_v[1] = 4'b0011; tick();
    check("xor_y_0011", 1, dut_y[1], 1'b0);
    check("xor_fall_0011", 1, dut_fall[1], 1'b1);
    d_v[1] = 4'b0111; tick();
    check("xor_y_0111", 1, dut_y[1], 1'b1);
    check("xor_rise_0111", 1, dut_rise[1], 1'b1);
    d_v[1] = 4'b0000;
    ticks(8);
    check("post_rst_y", 0, dut_y[0], 1'b1);

    // Stable change reaches y on the 6th edge
    d_v[0] = 4'b0010;
    ticks(5);
    check("lat_y_edge5", 0, dut_y[0], 1'b1);
    tick();
    check("lat_y_edge6", 0, dut_y[0], 1'b0);
    check("lat_fall_edge6", 0, dut_fall[0], 1'b1);
    check("lat_rise_edge6", 0, dut_rise[0], 1'b0);
    tick();
    check("lat_fall_edge7", 0, dut_fall[0], 1'b0);
    d_v[0] = 4'b0000;
    ticks(6);
    check("back_y", 0, dut_y[0], 1'b1);
    ticks(2);

    // 3-clock glitch is swallowed, 4-clock pulse passes
    d_v[0] = 4'b0001; ticks(3);
    d_v[0] = 4'b0000; ticks(10);
    check("glitch3_y", 0, dut_y[0], 1'b1);
    d_v[0] = 4'b0001; ticks(4);
    d_v[0] = 4'b0000; ticks(2);
    check("pulse4_y_low", 0, dut_y[0], 1'b0);
    ticks(4);
    check("pulse4_y_back", 0, dut_y[0], 1'b1);

    // Enable low freezes the filter
    en_v[0] = 1'b0;
    d_v[0]  = 4'b0100;
    ticks(10);
    check("en_hold_y", 0, dut_y[0], 1'b1);
    en_v[0] = 1'b1;
    ticks(3);
    check("en_y_edge3", 0, dut_y[0], 1'b1);
    tick();
    check("en_y_edge4", 0, dut_y[0], 1'b0);

    // Reset while the counter sits at 2
    d_v[0] = 4'b0000;
    ticks(4);
    reset_n = 1'b0;
    #1;
    check("async_rst_y", 0, dut_y[0], 1'b1);
    check("async_rst_fall", 0, dut_fall[0], 1'b0);
    tick();
    reset_n = 1'b1;
    d_v[0]  = 4'b0010;
    ticks(5);
    check("rel_y_edge5", 0, dut_y[0], 1'b1);
    tick();
    check("rel_y_edge6", 0, dut_y[0], 1'b0);

    // Randomised traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) d_v[0] = 4'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) d_v[1] = 4'($urandom_range(0, 15));
      en_v[0] = ($urandom_range(0, 9) != 0);
      en_v[1] = ($urandom_range(0, 9) != 0);
      reset_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    reset_n = 1'b1;
    ticks(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
